// File: rtl/cola_impresion.sv
// cola_impresion: print-job initiator for the color and black printer channels.
// Jobs ({color, paginas}) are queued in a small FIFO and dispatched in order to the
// matching channel as a one-cycle start strobe plus page code. The FSM then waits for
// the channel's fin level, and holds the queue while the head channel reports ink empty.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   prendido              power enable (blocks acceptance and leaving IDLE)
//   pedir/color_in/paginas_in  job request strobe and its payload
//   error_color/negro     ink-empty levels; fin_color/negro  job-complete levels
//   senal_color/negra     one-cycle start strobes; paginas  page code in flight
//   ocupado, esperando_tinta  FSM not idle / blocked on ink
//   vacio, lleno, cuenta  FIFO status and occupancy (excludes job in flight)
//   rechazado             one-cycle pulse on a dropped request
//   falla                 sticky timeout flag
module cola_impresion #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    prendido,
  input  logic                    pedir,
  input  logic                    color_in,
  input  logic [1:0]              paginas_in,
  input  logic                    error_color,
  input  logic                    error_negro,
  input  logic                    fin_color,
  input  logic                    fin_negro,
  output logic                    senal_color,
  output logic                    senal_negra,
  output logic [1:0]              paginas,
  output logic                    ocupado,
  output logic                    esperando_tinta,
  output logic                    vacio,
  output logic                    lleno,
  output logic [$clog2(DEPTH):0]  cuenta,
  output logic                    rechazado,
  output logic                    falla
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CuentaLlena = (AW + 1)'(DEPTH);
  // ESPERA lasts at most TIMEOUT cycles: counter runs 0..TIMEOUT-1.
  localparam logic [7:0]  CntUltimo   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StEmitir, StEspera, StLiberar, StBloqueado
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          canal_q;            // channel of job in flight: 1 = color
  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cuenta_d;

  logic          push, pop, rechazo, timeout_hit, entrar_emitir;
  logic [2:0]    cabeza;
  logic          cabeza_color, error_cabeza, fin_activo;

  always_comb begin
    push          = pedir & prendido & (paginas_in != 2'd0) & ~lleno;
    rechazo       = pedir & (~prendido | (paginas_in == 2'd0) | lleno);
    cabeza        = mem_q[rd_ptr_q];
    cabeza_color  = cabeza[2];
    error_cabeza  = cabeza_color ? error_color : error_negro;
    fin_activo    = canal_q ? fin_color : fin_negro;

    estado_d    = estado_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    timeout_hit = 1'b0;

    unique case (estado_q)
      StIdle: begin
        if (!vacio && prendido) begin
          estado_d = error_cabeza ? StBloqueado : StEmitir;
        end
      end
      StEmitir: begin
        pop      = 1'b1;
        cnt_d    = '0;
        estado_d = StEspera;
      end
      StEspera: begin
        if (fin_activo) begin
          estado_d = StLiberar;
        end else if (cnt_q == CntUltimo) begin
          timeout_hit = 1'b1;
          estado_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Wait for fin to drop so one fin level cannot complete two jobs.
      StLiberar: begin
        if (!fin_activo) estado_d = StIdle;
      end
      StBloqueado: begin
        if (!error_cabeza) estado_d = StIdle;
      end
      default: estado_d = StIdle;
    endcase

    entrar_emitir = (estado_q == StIdle) && (estado_d == StEmitir);

    cuenta_d = cuenta;
    unique case ({push, pop})
      2'b10:   cuenta_d = cuenta + (AW + 1)'(1);
      2'b01:   cuenta_d = cuenta - (AW + 1)'(1);
      default: cuenta_d = cuenta;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q        <= StIdle;
      cnt_q           <= '0;
      canal_q         <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      cuenta          <= '0;
      vacio           <= 1'b1;
      lleno           <= 1'b0;
      senal_color     <= 1'b0;
      senal_negra     <= 1'b0;
      paginas         <= 2'd0;
      ocupado         <= 1'b0;
      esperando_tinta <= 1'b0;
      rechazado       <= 1'b0;
      falla           <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {color_in, paginas_in};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cuenta <= cuenta_d;
      vacio  <= (cuenta_d == '0);
      lleno  <= (cuenta_d == CuentaLlena);
      // Strobe and page code are launched on entry so they line up with EMITIR.
      senal_color <= entrar_emitir & cabeza_color;
      senal_negra <= entrar_emitir & ~cabeza_color;
      if (entrar_emitir) begin
        paginas <= cabeza[1:0];
        canal_q <= cabeza_color;
      end
      ocupado         <= (estado_d != StIdle);
      esperando_tinta <= (estado_d == StBloqueado);
      rechazado       <= rechazo;
      falla           <= falla | timeout_hit;
    end
  end

endmodule

// File: tb/tb_cola_impresion.sv
// Directed bench for cola_impresion (DEPTH=4, TIMEOUT=10). Inputs change 1 ns after
// each rising edge; outputs are checked at that same point.
module tb_cola_impresion;

  logic       clk, reset, prendido, pedir, color_in;
  logic [1:0] paginas_in;
  logic       error_color, error_negro, fin_color, fin_negro;
  logic       senal_color, senal_negra, ocupado, esperando_tinta;
  logic       vacio, lleno, rechazado, falla;
  logic [1:0] paginas;
  logic [2:0] cuenta;

  int n_checks = 0;
  int n_errors = 0;

  cola_impresion #(.DEPTH(4), .TIMEOUT(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .prendido        (prendido),
    .pedir           (pedir),
    .color_in        (color_in),
    .paginas_in      (paginas_in),
    .error_color     (error_color),
    .error_negro     (error_negro),
    .fin_color       (fin_color),
    .fin_negro       (fin_negro),
    .senal_color     (senal_color),
    .senal_negra     (senal_negra),
    .paginas         (paginas),
    .ocupado         (ocupado),
    .esperando_tinta (esperando_tinta),
    .vacio           (vacio),
    .lleno           (lleno),
    .cuenta          (cuenta),
    .rechazado       (rechazado),
    .falla           (falla)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic request(input logic c, input logic [1:0] p);
    pedir      = 1'b1;
    color_in   = c;
    paginas_in = p;
  endtask

  // Drain table: J1 color/1, J2 black/3, J3 color/2, J4 black/1, J5 color/3
  logic       job_color [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] job_pag   [5] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3};

  initial begin
    reset = 1'b0; prendido = 1'b1; pedir = 1'b0; color_in = 1'b0; paginas_in = 2'd0;
    error_color = 1'b0; error_negro = 1'b0; fin_color = 1'b0; fin_negro = 1'b0;
    tick(); tick();
    check("rst_cuenta", 32'(cuenta), 0);
    check("rst_vacio", 32'(vacio), 1);
    check("rst_lleno", 32'(lleno), 0);
    check("rst_senal", 32'({senal_color, senal_negra}), 0);
    check("rst_paginas", 32'(paginas), 0);
    check("rst_flags", 32'({ocupado, esperando_tinta, rechazado, falla}), 0);
    reset = 1'b1;
    tick();

    // Single black job, 2 pages
    request(1'b0, 2'd2);
    tick();
    check("t1_cuenta1", 32'(cuenta), 1);
    check("t1_no_strobe_yet", 32'(senal_negra), 0);
    pedir = 1'b0;
    tick();
    check("t1_senal_negra", 32'(senal_negra), 1);
    check("t1_senal_color", 32'(senal_color), 0);
    check("t1_paginas", 32'(paginas), 2);
    check("t1_ocupado", 32'(ocupado), 1);
    tick();
    check("t1_strobe_off", 32'(senal_negra), 0);
    check("t1_cuenta0", 32'(cuenta), 0);
    fin_negro = 1'b1;
    tick(); tick(); tick();
    check("t1_ocupado_fin", 32'(ocupado), 1);
    check("t1_paginas_hold", 32'(paginas), 2);
    fin_negro = 1'b0;
    tick();
    check("t1_ocupado_drop", 32'(ocupado), 0);

    // Fill and overflow
    for (int j = 0; j < 5; j++) begin
      request(job_color[j], job_pag[j]);
      tick();
      if (j == 1) begin
        check("t2_first_strobe", 32'(senal_color), 1);
        check("t2_first_pag", 32'(paginas), 1);
      end
    end
    check("t2_cuenta_full", 32'(cuenta), 4);
    check("t2_lleno", 32'(lleno), 1);
    request(1'b0, 2'd1);
    tick();
    check("t2_rechazado", 32'(rechazado), 1);
    check("t2_cuenta_kept", 32'(cuenta), 4);
    pedir = 1'b0;
    tick();
    check("t2_rechazado_pulse", 32'(rechazado), 0);
    for (int j = 1; j < 5; j++) begin
      if (job_color[j-1]) fin_color = 1'b1; else fin_negro = 1'b1;
      tick();
      fin_color = 1'b0; fin_negro = 1'b0;
      tick(); tick();
      check($sformatf("t2_senal_color_j%0d", j), 32'(senal_color), 32'(job_color[j]));
      check($sformatf("t2_senal_negra_j%0d", j), 32'(senal_negra), 32'(!job_color[j]));
      check($sformatf("t2_paginas_j%0d", j), 32'(paginas), 32'(job_pag[j]));
      tick();
      check($sformatf("t2_cuenta_j%0d", j), 32'(cuenta), 32'(4 - j));
    end
    check("t2_lleno_clear", 32'(lleno), 0);
    fin_color = 1'b1; tick();
    fin_color = 1'b0; tick();
    check("t2_idle", 32'(ocupado), 0);
    check("t2_vacio", 32'(vacio), 1);

    // Ink empty on color
    error_color = 1'b1;
    request(1'b1, 2'd2);
    tick();
    pedir = 1'b0;
    tick();
    check("t3_esperando", 32'(esperando_tinta), 1);
    check("t3_cuenta", 32'(cuenta), 1);
    request(1'b0, 2'd1);
    tick();
    pedir = 1'b0;
    check("t3_accept_blocked", 32'(cuenta), 2);
    check("t3_no_strobe", 32'({senal_color, senal_negra}), 0);
    tick();
    check("t3_still_blocked", 32'(esperando_tinta), 1);
    error_color = 1'b0;
    tick();
    check("t3_esperando_fall", 32'(esperando_tinta), 0);
    check("t3_no_strobe2", 32'(senal_color), 0);
    tick();
    check("t3_senal_color", 32'(senal_color), 1);
    check("t3_paginas", 32'(paginas), 2);
    tick();
    fin_color = 1'b1; tick();
    fin_color = 1'b0; tick(); tick();
    check("t3_second_negra", 32'(senal_negra), 1);
    check("t3_second_pag", 32'(paginas), 1);
    tick();
    fin_negro = 1'b1; tick();
    fin_negro = 1'b0; tick();
    check("t3_idle", 32'(ocupado), 0);

    // Illegal request and power off
    request(1'b1, 2'd0);
    tick();
    check("t4_rech_pag0", 32'(rechazado), 1);
    check("t4_cuenta_pag0", 32'(cuenta), 0);
    pedir = 1'b0;
    tick();
    prendido = 1'b0;
    request(1'b0, 2'd3);
    tick();
    check("t4_rech_off", 32'(rechazado), 1);
    check("t4_cuenta_off", 32'(cuenta), 0);
    pedir = 1'b0; prendido = 1'b1;
    tick();

    // Timeout: 10 ESPERA cycles, then next job dispatched
    request(1'b0, 2'd3);
    tick();
    request(1'b1, 2'd1);
    tick();
    check("t5_strobe_a", 32'(senal_negra), 1);
    pedir = 1'b0;
    tick();
    repeat (9) tick();
    check("t5_no_falla_yet", 32'(falla), 0);
    check("t5_busy", 32'(ocupado), 1);
    tick();
    check("t5_falla", 32'(falla), 1);
    check("t5_idle", 32'(ocupado), 0);
    tick();
    check("t5_next_color", 32'(senal_color), 1);
    check("t5_next_pag", 32'(paginas), 1);
    tick();
    fin_color = 1'b1; tick();
    fin_color = 1'b0; tick();
    check("t5_falla_sticky", 32'(falla), 1);

    // Reset mid-job with two jobs queued
    request(1'b1, 2'd1); tick();
    request(1'b0, 2'd2); tick();
    request(1'b1, 2'd3); tick();
    pedir = 1'b0;
    tick();
    check("t6_queued", 32'(cuenta), 2);
    reset = 1'b0;
    #2;
    check("t6_cuenta", 32'(cuenta), 0);
    check("t6_vacio", 32'(vacio), 1);
    check("t6_flags", 32'({ocupado, esperando_tinta, rechazado, falla, lleno}), 0);
    check("t6_paginas", 32'(paginas), 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t6_no_strobe_%0d", k), 32'({senal_color, senal_negra, ocupado}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
